// File: rtl/status_sync_filter_pkg.sv
// =============================================================================
// Module   : status_sync_filter_pkg
// Brief    : Shared defaults and helpers for the status synchroniser/filter.
// Revision : 1.0
// =============================================================================
`default_nettype none

package status_sync_filter_pkg;

    localparam int c_sync_stages_default   = 3;
    localparam int c_stable_cycles_default = 4;
    localparam int c_coal_w                = 16;

    // Channel index width, never narrower than one bit.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/status_sync_filter_ch.sv
// =============================================================================
// Module   : status_sync_filter_ch
// Brief    : One channel: bitwise synchroniser, stability filter, status reg.
// Revision : 1.0
// =============================================================================
`default_nettype none

module status_sync_filter_ch
    import status_sync_filter_pkg::*;
#(
    parameter int WIDTH         = 2,
    parameter int SYNC_STAGES   = c_sync_stages_default,
    parameter int STABLE_CYCLES = c_stable_cycles_default
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_status,
    output logic             o_status_ok,
    output logic             o_upd
);

    localparam int               CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];

    logic [WIDTH-1:0] cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] status_q, status_d;
    logic             ok_q, ok_d;
    logic [WIDTH-1:0] w_sync;
    logic             w_upd;

    always_comb begin
        sync_d[0] = i_async;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign w_sync = sync_q[SYNC_STAGES-1];

    // A changing sample restarts the count; acceptance needs a full stable run.
    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        status_d = status_q;
        ok_d     = ok_q;
        w_upd    = 1'b0;
        if (w_sync != cand_q) begin
            cand_d = w_sync;
            cnt_d  = '0;
        end else if (cnt_q == CNT_MAX) begin
            ok_d = 1'b1;
            if (cand_q != status_q) begin
                status_d = cand_q;
                w_upd    = 1'b1;
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            cand_q   <= '0;
            cnt_q    <= '0;
            status_q <= '0;
            ok_q     <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            status_q <= status_d;
            ok_q     <= ok_d;
        end
    end

    assign o_status    = status_q;
    assign o_status_ok = ok_q;
    assign o_upd       = w_upd;

endmodule

`default_nettype wire

// File: rtl/status_sync_filter.sv
// =============================================================================
// Module   : status_sync_filter
// Brief    : Multi-channel status synchroniser with round-robin change events.
// Revision : 1.0
// =============================================================================
`default_nettype none

module status_sync_filter
    import status_sync_filter_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int WIDTH         = 2,
    parameter int SYNC_STAGES   = c_sync_stages_default,
    parameter int STABLE_CYCLES = c_stable_cycles_default
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH*WIDTH-1:0]       async_in,
    output logic [NUM_CH*WIDTH-1:0]       status_out,
    output logic [NUM_CH-1:0]             status_ok,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [ch_idx_w(NUM_CH)-1:0]   evt_ch,
    output logic [WIDTH-1:0]              evt_value,
    output logic [c_coal_w-1:0]           coalesce_cnt
);

    localparam int CH_W = ch_idx_w(NUM_CH);

    logic [NUM_CH*WIDTH-1:0] w_status;
    logic [NUM_CH-1:0]       w_ok;
    logic [NUM_CH-1:0]       w_upd;

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            status_sync_filter_ch #(
                .WIDTH         (WIDTH),
                .SYNC_STAGES   (SYNC_STAGES),
                .STABLE_CYCLES (STABLE_CYCLES)
            ) u_ch (
                .clk         (clk),
                .rst         (rst),
                .i_async     (async_in[c*WIDTH +: WIDTH]),
                .o_status    (w_status[c*WIDTH +: WIDTH]),
                .o_status_ok (w_ok[c]),
                .o_upd       (w_upd[c])
            );
        end
    endgenerate

    logic [NUM_CH-1:0]   pending_q, pending_d;
    logic [CH_W-1:0]     ptr_q, ptr_d;
    logic                evt_valid_q, evt_valid_d;
    logic [CH_W-1:0]     evt_ch_q, evt_ch_d;
    logic [WIDTH-1:0]    evt_value_q, evt_value_d;
    logic [c_coal_w-1:0] coal_q, coal_d;

    logic                w_load;
    logic                w_grant_vld;
    logic [CH_W-1:0]     w_grant;
    logic [WIDTH-1:0]    w_grant_value;

    assign w_load = !evt_valid_q || evt_ready;

    always_comb begin
        w_grant_vld   = 1'b0;
        w_grant       = '0;
        w_grant_value = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (!w_grant_vld && (c == (int'(ptr_q) + i) % NUM_CH) && pending_q[c]) begin
                    w_grant_vld = 1'b1;
                    w_grant     = CH_W'(c);
                end
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_grant == CH_W'(c)) begin
                w_grant_value = w_status[c*WIDTH +: WIDTH];
            end
        end
    end

    // Grant clears first so a same-edge update on the granted channel re-arms it.
    always_comb begin
        pending_d   = pending_q;
        ptr_d       = ptr_q;
        evt_valid_d = evt_valid_q;
        evt_ch_d    = evt_ch_q;
        evt_value_d = evt_value_q;
        coal_d      = coal_q;
        if (w_load) begin
            evt_valid_d = w_grant_vld;
            if (w_grant_vld) begin
                evt_ch_d    = w_grant;
                evt_value_d = w_grant_value;
                ptr_d       = (int'(w_grant) == NUM_CH - 1) ? '0 : w_grant + CH_W'(1);
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_load && w_grant_vld && (w_grant == CH_W'(c))) begin
                pending_d[c] = 1'b0;
            end
            if (w_upd[c]) begin
                if (pending_q[c] && !(w_load && w_grant_vld && (w_grant == CH_W'(c)))
                        && (coal_d != '1)) begin
                    coal_d = coal_d + c_coal_w'(1);
                end
                pending_d[c] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q   <= '0;
            ptr_q       <= '0;
            evt_valid_q <= 1'b0;
            evt_ch_q    <= '0;
            evt_value_q <= '0;
            coal_q      <= '0;
        end else begin
            pending_q   <= pending_d;
            ptr_q       <= ptr_d;
            evt_valid_q <= evt_valid_d;
            evt_ch_q    <= evt_ch_d;
            evt_value_q <= evt_value_d;
            coal_q      <= coal_d;
        end
    end

    assign status_out   = w_status;
    assign status_ok    = w_ok;
    assign evt_valid    = evt_valid_q;
    assign evt_ch       = evt_ch_q;
    assign evt_value    = evt_value_q;
    assign coalesce_cnt = coal_q;

endmodule

`default_nettype wire
